hc595_rx: RTL and testbench

//  Receiving end of the 74HC595 serial display link (ds/shcp/stcp/oe) that the display driver transmits.

---
 rtl/hc595_rx_pkg.sv | 57 +++++
 rtl/hc595_in_sync.sv | 29 ++
 rtl/hc595_rx.sv | 122 ++++++++++++
 tb/tb_hc595_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hc595_rx_pkg.sv
// Shared widths, segment patterns and the segment-to-hex decoder for the 74HC595 display link.
package hc595_rx_pkg;

  localparam int unsigned DEF_SEL_W  = 6;
  localparam int unsigned DEF_SEG_W  = 8;
  localparam int unsigned DEF_DATA_W = DEF_SEL_W + DEF_SEG_W;

  // Active-low common-anode patterns on seg[6:0], indexed by hex value.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic       vld;
    logic [3:0] digit;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] s);
    seg_dec_t r;
    r.vld   = 1'b1;
    r.digit = 4'h0;
    case (s)
      SEG_0:   r.digit = 4'h0;
      SEG_1:   r.digit = 4'h1;
      SEG_2:   r.digit = 4'h2;
      SEG_3:   r.digit = 4'h3;
      SEG_4:   r.digit = 4'h4;
      SEG_5:   r.digit = 4'h5;
      SEG_6:   r.digit = 4'h6;
      SEG_7:   r.digit = 4'h7;
      SEG_8:   r.digit = 4'h8;
      SEG_9:   r.digit = 4'h9;
      SEG_A:   r.digit = 4'hA;
      SEG_B:   r.digit = 4'hB;
      SEG_C:   r.digit = 4'hC;
      SEG_D:   r.digit = 4'hD;
      SEG_E:   r.digit = 4'hE;
      SEG_F:   r.digit = 4'hF;
      default: r.vld   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hc595_in_sync.sv
// Multi-flop synchronizer for one link pin, with a rising-edge pulse off the synchronized level.
module hc595_in_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c
);

  logic [STAGES-1:0] s;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s   <= {STAGES{RST_VAL}};
      q_d <= RST_VAL;
    end else begin
      s   <= {s[STAGES-2:0], d};
      q_d <= s[STAGES-1];
    end
  end

  assign q      = s[STAGES-1];
  assign rise_c = s[STAGES-1] & ~q_d;

endmodule

// File: rtl/hc595_rx.sv
// 74HC595 link receiver: rebuilds {sel, seg} frames from ds/shcp/stcp/oe and decodes the segment digit.
module hc595_rx
  import hc595_rx_pkg::*;
#(
  parameter int unsigned SEL_W       = DEF_SEL_W,
  parameter int unsigned SEG_W       = DEF_SEG_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     ds,
  input  logic                     shcp,
  input  logic                     stcp,
  input  logic                     oe,
  output logic [SEL_W+SEG_W-1:0]   par_data,
  output logic [SEL_W-1:0]         sel,
  output logic [SEG_W-1:0]         seg,
  output logic                     data_vld,
  output logic                     frame_err,
  output logic                     out_en,
  output logic [3:0]               digit,
  output logic                     digit_vld,
  output logic                     dp
);

  localparam int unsigned DATA_W = SEL_W + SEG_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 2);

  logic ds_s, shcp_s, stcp_s, oe_s;
  logic shcp_rise, stcp_rise;
  logic unused_ds_rise, unused_oe_rise, unused_shcp_lvl, unused_stcp_lvl;

  hc595_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ds (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(ds), .q(ds_s), .rise_c(unused_ds_rise)
  );
  hc595_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_shcp (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(shcp), .q(unused_shcp_lvl), .rise_c(shcp_rise)
  );
  hc595_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_stcp (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(stcp), .q(unused_stcp_lvl), .rise_c(stcp_rise)
  );
  hc595_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oe (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(oe), .q(oe_s), .rise_c(unused_oe_rise)
  );

  assign shcp_s = unused_shcp_lvl;
  assign stcp_s = unused_stcp_lvl;

  logic [DATA_W-1:0] sh, sh_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [DATA_W-1:0] par_nxt;
  logic              vld_nxt, err_nxt, known, known_nxt;
  logic              out_en_nxt, digit_vld_nxt, dp_nxt;
  logic [3:0]        digit_nxt;
  seg_dec_t          dec_c;

  assign dec_c = seg_decode(sh[6:0]);

  // Latch samples the pre-shift register and count, so a coincident shift starts the next frame.
  always_comb begin
    sh_nxt    = sh;
    cnt_nxt   = bit_cnt;
    par_nxt   = par_data;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    known_nxt = known;
    digit_nxt = digit;
    dp_nxt    = dp;
    if (stcp_rise) begin
      if (bit_cnt == CNT_W'(DATA_W)) begin
        par_nxt   = sh;
        vld_nxt   = 1'b1;
        known_nxt = dec_c.vld;
        digit_nxt = dec_c.digit;
        dp_nxt    = ~sh[SEG_W-1];
      end else begin
        err_nxt   = 1'b1;
      end
      cnt_nxt = '0;
    end
    if (shcp_rise) begin
      sh_nxt = {sh[DATA_W-2:0], ds_s};
      if (stcp_rise) begin
        cnt_nxt = CNT_W'(1);
      end else if (bit_cnt != CNT_W'(DATA_W + 1)) begin
        cnt_nxt = bit_cnt + CNT_W'(1);
      end
    end
    out_en_nxt    = ~oe_s;
    digit_vld_nxt = out_en_nxt & known_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh        <= '0;
      bit_cnt   <= '0;
      par_data  <= '0;
      data_vld  <= 1'b0;
      frame_err <= 1'b0;
      known     <= 1'b0;
      digit     <= 4'h0;
      dp        <= 1'b0;
      out_en    <= 1'b0;
      digit_vld <= 1'b0;
    end else begin
      sh        <= sh_nxt;
      bit_cnt   <= cnt_nxt;
      par_data  <= par_nxt;
      data_vld  <= vld_nxt;
      frame_err <= err_nxt;
      known     <= known_nxt;
      digit     <= digit_nxt;
      dp        <= dp_nxt;
      out_en    <= out_en_nxt;
      digit_vld <= digit_vld_nxt;
    end
  end

  assign sel = par_data[DATA_W-1:SEG_W];
  assign seg = par_data[SEG_W-1:0];

endmodule

// File: tb/tb_hc595_rx.sv
// Directed bench for hc595_rx: frames are bit-banged on the pins, expected results go through a scoreboard queue.
`timescale 1ns/1ps
module tb_hc595_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        ds, shcp, stcp, oe;
  logic [13:0] par_data;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        data_vld, frame_err, out_en, digit_vld, dp;
  logic [3:0]  digit;

  hc595_rx dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .par_data(par_data), .sel(sel), .seg(seg), .data_vld(data_vld), .frame_err(frame_err),
    .out_en(out_en), .digit(digit), .digit_vld(digit_vld), .dp(dp)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [13:0] par;
    logic [3:0]  digit;
    logic        dv;
    logic        dp;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  logic [13:0] last_par = 14'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [13:0] f, input logic oe_pin);
    logic [6:0] pats [16];
    exp_t e;
    pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    e.par   = f;
    e.digit = 4'h0;
    e.dv    = 1'b0;
    e.dp    = ~f[7];
    for (int i = 0; i < 16; i++) begin
      if (pats[i] == f[6:0]) begin
        e.digit = 4'(i);
        e.dv    = ~oe_pin;
      end
    end
    return e;
  endfunction

  // Scoreboard consumer: every data_vld pops one expected frame.
  always @(negedge sys_clk) begin
    if (frame_err) err_cnt++;
    if (data_vld) begin
      if (sb.size() == 0) begin
        chk("spurious_data_vld", 32'(data_vld), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("par_data",  32'(par_data),  32'(e.par));
        chk("sel",       32'(sel),       32'(e.par[13:8]));
        chk("seg",       32'(seg),       32'(e.par[7:0]));
        chk("digit",     32'(digit),     32'(e.digit));
        chk("digit_vld", 32'(digit_vld), 32'(e.dv));
        chk("dp",        32'(dp),        32'(e.dp));
        last_par = e.par;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      shcp = 1'b0;
      ds   = v[i];
      cyc(2);
      shcp = 1'b1;
      cyc(2);
    end
    shcp = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_stcp();
    stcp = 1'b1;
    cyc(2);
    stcp = 1'b0;
    cyc(2);
  endtask

  task automatic send_frame(input logic [13:0] f);
    send_bits({2'b00, f}, 14);
    sb.push_back(model(f, oe));
    pulse_stcp();
  endtask

  task automatic settle(input string tag);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      cyc(1);
      budget++;
    end
    cyc(6);
    chk({tag, "_queue_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_frame_err_count"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_par_data"},  32'(par_data), 32'd0);
    chk({tag, "_sel_seg"},   32'({sel, seg}), 32'd0);
    chk({tag, "_pulses"},    32'({data_vld, frame_err}), 32'd0);
    chk({tag, "_out_en"},    32'(out_en), 32'd0);
    chk({tag, "_digit"},     32'({digit_vld, digit}), 32'd0);
    chk({tag, "_dp"},        32'(dp), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;

    // 1: reset and idle release
    cyc(5);
    chk_reset_outputs("reset");
    sys_rst_n = 1'b1;
    cyc(10);
    chk_reset_outputs("idle");
    settle("idle");

    // 2: first good frame with outputs enabled
    oe = 1'b0;
    cyc(6);
    chk("out_en_follows_oe", 32'(out_en), 32'd1);
    send_frame(14'h3EC0);
    settle("frame_3EC0");

    // 3: short frame, then good frame
    send_bits(16'h0ABC, 13);
    exp_err++;
    pulse_stcp();
    settle("short_frame");
    chk("par_held_after_short", 32'(par_data), 32'(last_par));
    send_frame(14'h3DF9);
    settle("frame_3DF9");

    // 4: long frame saturates the count, then good frame
    send_bits(16'hFFFF, 16);
    exp_err++;
    pulse_stcp();
    settle("long_frame");
    chk("par_held_after_long", 32'(par_data), 32'(last_par));
    send_frame(14'h2AA4);
    settle("frame_2AA4");

    // 5: 15th shift coincides with the latch; that bit starts the next frame
    send_bits({2'b00, 14'h3BA4}, 14);
    sb.push_back(model(14'h3BA4, oe));
    ds = 1'b1;
    cyc(2);
    shcp = 1'b1;
    stcp = 1'b1;
    cyc(2);
    shcp = 1'b0;
    stcp = 1'b0;
    cyc(2);
    send_bits({3'b000, 13'h1F30}, 13);
    sb.push_back(model(14'h3F30, oe));
    pulse_stcp();
    settle("coincident");

    // 6: reset mid-frame, blank segment frame, then disabled output
    send_bits(16'h007F, 7);
    sys_rst_n = 1'b0;
    cyc(3);
    chk_reset_outputs("mid_reset");
    sys_rst_n = 1'b1;
    cyc(6);
    send_frame(14'h05FF);
    settle("blank_frame");
    oe = 1'b1;
    cyc(6);
    chk("out_en_off", 32'(out_en), 32'd0);
    send_frame(14'h05FF);
    settle("blank_oe_off");
    send_frame(14'h0440);
    settle("zero_oe_off");
    chk("digit_vld_gated", 32'(digit_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
